aes_keyrom_arb: RTL and testbench

AES_KEYROM_ARB -- requirements
Module: aes_keyrom_arb

---
 rtl/aes_keyrom_arb.sv | 186 ++++++++++++++++++
 tb/tb_aes_keyrom_arb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_keyrom_arb.sv
`default_nettype none
// ============================================================================
// Module   : aes_keyrom_arb
// Purpose  : Round-key store loaded by the key generator and read by the
//            encrypter/decrypter through a round-robin arbitrated port.
//            Optional zeroization on flush: define AES_KEYROM_ZEROIZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_keyrom_arb #(
  parameter int N_KEYS = 15
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         kg_valid,
  input  logic [127:0] kg_key,
  output logic         kg_ready,
  input  logic         enc_req,
  input  logic [3:0]   enc_addr,
  output logic         enc_gnt,
  output logic         enc_rvalid,
  input  logic         dec_req,
  input  logic [3:0]   dec_addr,
  output logic         dec_gnt,
  output logic         dec_rvalid,
  output logic [127:0] rd_key,
  output logic         rd_err,
  input  logic         flush,
  output logic         keys_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
`ifdef AES_KEYROM_ZEROIZE_EN
    , CLEAR = 2'd3
`endif
  } state_t;

  localparam logic [4:0] cLastIdx = 5'(N_KEYS - 1);
  localparam logic [4:0] cNumKeys = 5'(N_KEYS);
`ifdef AES_KEYROM_ZEROIZE_EN
  localparam state_t cFlushTarget = CLEAR;
`else
  localparam state_t cFlushTarget = EMPTY;
`endif

  state_t         rState;
  state_t         wStateNext;
  logic [4:0]     rWrPtr;
  logic           rLastGntDec;
  logic           rKeysReady;
  logic           rEncRvalid;
  logic           rDecRvalid;
  logic           rRdErr;
  logic [127:0]   rRdKey;
  logic [127:0]   rMem [N_KEYS];

  logic           wWrite;
  logic           wKgReady;
  logic           wEncGnt;
  logic           wDecGnt;
  logic           wFlushAct;
  logic           wClear;
  logic [3:0]     wGntAddr;
  logic           wAddrOk;

`ifdef AES_KEYROM_ZEROIZE_EN
  logic [4:0]     rClrPtr;
`endif

  // Next-state, handshake and grant decode
  always_comb begin
    wStateNext = rState;
    wKgReady   = 1'b0;
    wWrite     = 1'b0;
    wEncGnt    = 1'b0;
    wDecGnt    = 1'b0;
    wFlushAct  = 1'b0;
    wClear     = 1'b0;
    case (rState)
      EMPTY: begin
        wKgReady = 1'b1;
        if (kg_valid) begin
          wWrite     = 1'b1;
          wStateNext = (rWrPtr == cLastIdx) ? READY : LOAD;
        end
      end
      LOAD: begin
        wKgReady = 1'b1;
        if (flush) begin
          wFlushAct  = 1'b1;
          wStateNext = cFlushTarget;
        end else if (kg_valid) begin
          wWrite = 1'b1;
          if (rWrPtr == cLastIdx) wStateNext = READY;
        end
      end
      READY: begin
        if (flush) begin
          wFlushAct  = 1'b1;
          wStateNext = cFlushTarget;
        end else if (enc_req && dec_req) begin
          wEncGnt = rLastGntDec;
          wDecGnt = !rLastGntDec;
        end else begin
          wEncGnt = enc_req;
          wDecGnt = dec_req;
        end
      end
`ifdef AES_KEYROM_ZEROIZE_EN
      CLEAR: begin
        wClear = 1'b1;
        if (rClrPtr == cLastIdx) wStateNext = EMPTY;
      end
`endif
      default: wStateNext = EMPTY;
    endcase
  end

  assign wGntAddr = wDecGnt ? dec_addr : enc_addr;
  assign wAddrOk  = ({1'b0, wGntAddr} < cNumKeys);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rState      <= EMPTY;
      rWrPtr      <= 5'd0;
      rLastGntDec <= 1'b1;
      rKeysReady  <= 1'b0;
      rEncRvalid  <= 1'b0;
      rDecRvalid  <= 1'b0;
      rRdErr      <= 1'b0;
      rRdKey      <= '0;
    end else begin
      rState     <= wStateNext;
      rKeysReady <= (wStateNext == READY);
      rEncRvalid <= wEncGnt;
      rDecRvalid <= wDecGnt;
      rRdErr     <= (wEncGnt || wDecGnt) && !wAddrOk;
      if (wFlushAct) begin
        rWrPtr <= 5'd0;
      end else if (wWrite) begin
        rWrPtr <= rWrPtr + 5'd1;
      end
      if (wEncGnt || wDecGnt) begin
        rLastGntDec <= wDecGnt;
        rRdKey      <= wAddrOk ? rMem[wGntAddr] : '0;
      end
    end
  end

`ifdef AES_KEYROM_ZEROIZE_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rClrPtr <= 5'd0;
    end else if (wFlushAct) begin
      rClrPtr <= 5'd0;
    end else if (wClear) begin
      rClrPtr <= rClrPtr + 5'd1;
    end
  end
`endif

  // Key storage deliberately has no reset
  always_ff @(posedge clk) begin
    if (wWrite) begin
      rMem[rWrPtr[3:0]] <= kg_key;
    end
`ifdef AES_KEYROM_ZEROIZE_EN
    else if (wClear) begin
      rMem[rClrPtr[3:0]] <= '0;
    end
`endif
  end

  assign kg_ready   = wKgReady;
  assign enc_gnt    = wEncGnt;
  assign dec_gnt    = wDecGnt;
  assign enc_rvalid = rEncRvalid;
  assign dec_rvalid = rDecRvalid;
  assign rd_err     = rRdErr;
  assign rd_key     = rRdKey;
  assign keys_ready = rKeysReady;

endmodule
`default_nettype wire

// File: tb/tb_aes_keyrom_arb.sv
`default_nettype none
// Directed bench for aes_keyrom_arb: load, arbitrated reads, flush and reset,
// with read responses predicted into a scoreboard queue.
module tb_aes_keyrom_arb;
  localparam int N = 15;

  logic         clk = 1'b0;
  logic         resetn;
  logic         kg_valid;
  logic [127:0] kg_key;
  logic         kg_ready;
  logic         enc_req, dec_req;
  logic [3:0]   enc_addr, dec_addr;
  logic         enc_gnt, dec_gnt, enc_rvalid, dec_rvalid;
  logic [127:0] rd_key;
  logic         rd_err;
  logic         flush;
  logic         keys_ready;

  always #5 clk = ~clk;

  aes_keyrom_arb #(.N_KEYS(N)) dut (
    .clk(clk), .resetn(resetn),
    .kg_valid(kg_valid), .kg_key(kg_key), .kg_ready(kg_ready),
    .enc_req(enc_req), .enc_addr(enc_addr), .enc_gnt(enc_gnt), .enc_rvalid(enc_rvalid),
    .dec_req(dec_req), .dec_addr(dec_addr), .dec_gnt(dec_gnt), .dec_rvalid(dec_rvalid),
    .rd_key(rd_key), .rd_err(rd_err), .flush(flush), .keys_ready(keys_ready)
  );

  typedef struct {
    logic         enc;
    logic         dec;
    logic [127:0] key;
    logic         err;
  } resp_t;

  resp_t        sbq[$];
  int           checks   = 0;
  int           failures = 0;
  logic [127:0] mKeys [16];
  bit           mReady;
  bit           mLastDec;
  logic [127:0] mRdKey;

  function automatic logic [127:0] keyOf(int i);
    return {96'hC0FFEE00_11223344_55667788, 32'(i)};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One arbitration cycle: predict grants and response, then check both
  task automatic cyc(input bit e, input logic [3:0] ea, input bit d,
                     input logic [3:0] da, input bit f);
    resp_t r;
    bit eg, dg;
    int a;
    enc_req = e; enc_addr = ea; dec_req = d; dec_addr = da; flush = f;
    #1;
    eg = 1'b0; dg = 1'b0;
    if (mReady && !f) begin
      if (e && d) begin
        eg = mLastDec;
        dg = !mLastDec;
      end else begin
        eg = e;
        dg = d;
      end
    end
    chk("enc_gnt", 128'(enc_gnt), 128'(eg));
    chk("dec_gnt", 128'(dec_gnt), 128'(dg));
    r.enc = eg; r.dec = dg; r.err = 1'b0; r.key = mRdKey;
    if (eg || dg) begin
      a = dg ? int'(da) : int'(ea);
      if (a >= N) begin
        r.key = '0;
        r.err = 1'b1;
      end else begin
        r.key = mKeys[a];
      end
      mRdKey   = r.key;
      mLastDec = dg;
    end
    sbq.push_back(r);
    if (f) mReady = 1'b0;
    @(posedge clk); #1;
    r = sbq.pop_front();
    chk("enc_rvalid", 128'(enc_rvalid), 128'(r.enc));
    chk("dec_rvalid", 128'(dec_rvalid), 128'(r.dec));
    chk("rd_key", rd_key, r.key);
    chk("rd_err", 128'(rd_err), 128'(r.err));
    enc_req = 1'b0; dec_req = 1'b0; flush = 1'b0;
  endtask

  task automatic loadKeys(int n, int base, bit gaps);
    for (int i = 0; i < n; i++) begin
      kg_valid = 1'b1;
      kg_key   = keyOf(base + i);
      mKeys[i] = kg_key;
      #1;
      chk("kg_ready_load", 128'(kg_ready), 128'(1'b1));
      @(posedge clk); #1;
      kg_valid = 1'b0;
      if (i == N - 1) begin
        chk("keys_ready_up", 128'(keys_ready), 128'(1'b1));
        chk("kg_ready_full", 128'(kg_ready), 128'(1'b0));
      end else begin
        chk("keys_ready_low", 128'(keys_ready), 128'(1'b0));
      end
      if (gaps && i < n - 1) begin
        @(posedge clk); #1;
      end
    end
    if (n == N) mReady = 1'b1;
  endtask

  task automatic afterFlush();
    int n;
    chk("keys_ready_flush", 128'(keys_ready), 128'(1'b0));
`ifdef AES_KEYROM_ZEROIZE_EN
    n = 0;
    while (!kg_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_len", 128'(n), 128'(N));
`else
    n = 0;
    chk("kg_ready_flush", 128'(kg_ready), 128'(1'b1));
`endif
  endtask

  initial begin
    resetn = 1'b0; kg_valid = 1'b0; kg_key = '0; flush = 1'b0;
    enc_req = 1'b0; dec_req = 1'b0; enc_addr = '0; dec_addr = '0;
    mReady = 1'b0; mLastDec = 1'b1; mRdKey = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_kg_ready", 128'(kg_ready), 128'(1'b1));
    chk("rst_keys_ready", 128'(keys_ready), 128'(1'b0));
    chk("rst_enc_rvalid", 128'(enc_rvalid), 128'(1'b0));
    chk("rst_dec_rvalid", 128'(dec_rvalid), 128'(1'b0));
    chk("rst_rd_err", 128'(rd_err), 128'(1'b0));
    chk("rst_rd_key", rd_key, 128'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    cyc(1, 4'd3, 1, 4'd4, 0);           // no grants while EMPTY
    loadKeys(N, 0, 1);                  // load with idle gaps

    kg_valid = 1'b1; kg_key = '1;       // ignored in READY
    @(posedge clk); #1;
    chk("kg_ready_ready", 128'(kg_ready), 128'(1'b0));
    kg_valid = 1'b0;

    repeat (4) cyc(1, 4'd1, 1, 4'd2, 0);  // contention: enc, dec, enc, dec
    cyc(1, 4'd3, 0, 4'd0, 0);
    cyc(0, 4'd0, 0, 4'd0, 0);           // rd_key held
    cyc(0, 4'd0, 1, 4'd15, 0);          // out of range
    cyc(1, 4'd14, 0, 4'd0, 0);          // last valid entry
    cyc(1, 4'd5, 0, 4'd0, 0);
    cyc(0, 4'd0, 1, 4'd2, 1);           // flush beats grant
    afterFlush();
    cyc(1, 4'd3, 0, 4'd0, 0);           // no grant after flush

    loadKeys(7, 16, 0);
    flush = 1'b1; kg_valid = 1'b1; kg_key = keyOf(99);
    @(posedge clk); #1;
    flush = 1'b0; kg_valid = 1'b0;
    afterFlush();
    loadKeys(N, 32, 0);                 // full reload needed
    cyc(1, 4'd0, 0, 4'd0, 0);
    cyc(0, 4'd0, 1, 4'd6, 0);
    cyc(1, 4'd9, 1, 4'd13, 0);

    // reset in the cycle after a grant
    enc_req = 1'b1; enc_addr = 4'd2;
    #1;
    chk("gnt_before_rst", 128'(enc_gnt), 128'(1'b1));
    @(posedge clk); #1;
    enc_req = 1'b0;
    resetn  = 1'b0;
    #1;
    chk("rst_mid_rvalid", 128'(enc_rvalid), 128'(1'b0));
    chk("rst_mid_rd_key", rd_key, 128'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_enc_rvalid", 128'(enc_rvalid), 128'(1'b0));
    chk("post_rst_dec_rvalid", 128'(dec_rvalid), 128'(1'b0));
    chk("post_rst_kg_ready", 128'(kg_ready), 128'(1'b1));
    chk("post_rst_keys_ready", 128'(keys_ready), 128'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
